spike_encoder: RTL and testbench
================================

Name: spike_encoder

Overview:
Rate-coding spike source that drives the axon input of a neuron. It accepts one unsigned intensity sample over a valid/ready handshake. It then emits a deterministic spike train on axon_o for WINDOW timesteps, using a phase accumulator. The spike count over a window is proportional to the intensity, so it forms the input layer feeding neuron instances.

Parameters:
DATA_W, 8, width of the intensity sample and of the phase accumulator
WINDOW, 16, timesteps per sample (WINDOW >= 2)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  reset, asynchronous, active-high
value_i  in  DATA_W  unsigned intensity sample
valid_i  in  1  sample present on value_i
ready_o  out  1  encoder idle and able to accept a sample
tick_i  in  1  timestep strobe; one timestep advances per high cycle
clear_i  in  1  synchronous abort of the current window
axon_o  out  1  spike pulse, one cycle wide, registered
done_o  out  1  one-cycle pulse when the window completes
spike_count_o  out  $clog2(WINDOW+1)  spikes emitted in the current or last window

Behaviour:
- Reset values while rst_i is high, applied asynchronously:
  - state=IDLE, acc=0, step=0, sample=0
  - axon_o=0, done_o=0, spike_count_o=0
  - ready_o=1, because it is decoded from state
- States: IDLE, RUN. ready_o = (state==IDLE).
- IDLE behaviour:
  - valid_i && ready_o at an edge latches value_i into sample and clears acc, step and spike_count_o. State then goes to RUN.
  - tick_i is ignored in IDLE, including on the acceptance cycle.
- RUN, on an edge with tick_i=1:
  - sum = {1'b0,acc} + {1'b0,sample}, which is DATA_W+1 bits.
  - acc <= sum[DATA_W-1:0].
  - axon_o <= sum[DATA_W].
  - spike_count_o increments when sum[DATA_W]=1.
  - step increments.
- RUN, on an edge with tick_i=0: axon_o <= 0 and all other state holds.
- axon_o is high for at most one cycle per tick. It is never high in the cycle after a non-tick edge.
- Window end:
  - The tick edge taken with step==WINDOW-1 sets done_o <= 1 and state <= IDLE.
  - That same edge still updates axon_o for the final timestep.
  - done_o is 0 on all other edges.
- Spikes per window = floor(sample*WINDOW / 2^DATA_W). The first tick never spikes unless sample*1 >= 2^DATA_W, which is impossible, so the first tick is always silent.
- valid_i while in RUN: ignored and not latched. value_i need not be held after acceptance.
- Back-to-back operation: ready_o is high the cycle after done_o, so a sample held valid is accepted then. Minimum gap is 1 idle cycle per window.
- clear_i in RUN, highest priority over tick_i:
  - state <= IDLE, axon_o <= 0, done_o stays 0.
  - spike_count_o holds its partial value until the next acceptance.
- clear_i in IDLE: no effect. clear_i together with valid_i in IDLE: the sample is accepted, because clear applies only in RUN.
- Async reset mid-RUN: outputs go to their reset values immediately. No done_o is emitted.
- Arithmetic is unsigned throughout. acc wraps modulo 2^DATA_W and the carry is the spike.
- step counts 0..WINDOW-1 in $clog2(WINDOW) bits and never wraps inside a window.

Decomposition:
- Shared package snn_pkg holds:
  - the encoder state enum (ENC_IDLE, ENC_RUN)
  - the default DATA_W / WINDOW constants for the input layer
- Sub-module: spike_phase_acc. It contains the accumulator register, the adder and carry-out, with ports for clock, reset, load-clear, advance, sample in and carry out.
- FSM, step counter, spike counter and handshake stay in spike_encoder.

Test Plan:
- value=128, WINDOW=16, tick_i held high -> spikes on ticks 2,4,...,16 (8 total); done_o coincides with the tick-16 spike; spike_count_o=8; ready_o=1 the next cycle.
- value=0 -> axon_o never high, done_o after 16 ticks, count 0. value=255 -> 15 spikes, tick 1 silent, count 15.
- value=64 with tick_i high every 3rd cycle -> spikes only after ticks 4,8,12,16; axon_o low on all other cycles; done_o 16 ticks after acceptance.
- valid_i held high with alternating values during RUN -> only the first value is used (check the count); the next value is accepted the cycle after done_o.
- clear_i pulsed at tick 5 with value=128 -> IDLE next cycle, no done_o, spike_count_o holds 2, next sample restarts the count at 0.
- rst_i asserted asynchronously mid-window (between edges) -> axon_o, done_o and spike_count_o go to 0 before the next edge; after release ready_o=1 and a fresh window runs correctly.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types and default sizing for the spiking-network input layer.
//   enc_state_t : encoder control state (idle / running a window)
//   ENC_DATA_W  : default intensity / phase-accumulator width
//   ENC_WINDOW  : default number of timesteps per encoded sample
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int ENC_DATA_W = 8;
  localparam int ENC_WINDOW = 16;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_phase_acc.sv
// -----------------------------------------------------------------------------
// spike_phase_acc
// Phase accumulator for rate coding. Every advance adds the sample to the
// accumulator modulo 2^DATA_W. The carry out of that add is the spike for the
// timestep, so the number of carries over k advances is floor(sample*k/2^DATA_W).
//
// Ports
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset (accumulator -> 0)
//   clr_i     : synchronous clear of the accumulator (new sample loaded)
//   adv_i     : take one timestep: acc <= acc + sample
//   sample_i  : intensity being encoded
//   carry_o   : combinational carry of acc + sample (spike if advanced now)
// -----------------------------------------------------------------------------
module spike_phase_acc
  import snn_pkg::*;
#(
  parameter int DATA_W = ENC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              carry_o
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;

  // One extra bit so the wrap of the accumulator shows up as the carry.
  assign sum     = {1'b0, acc} + {1'b0, sample_i};
  assign carry_o = sum[DATA_W];

  // NOTE: registers are written with <= so every flop samples the values that
  // existed before the edge; blocking assignments here would create
  // order-dependent simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc <= '0;
    end else if (clr_i) begin
      acc <= '0;
    end else if (adv_i) begin
      acc <= sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// -----------------------------------------------------------------------------
// spike_encoder
// Rate-coding spike source for the axon input of a neuron. A sample accepted
// over valid/ready is encoded as a deterministic spike train lasting WINDOW
// timesteps; spikes per window = floor(sample*WINDOW / 2^DATA_W).
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   value_i        : unsigned intensity sample
//   valid_i        : sample present on value_i
//   ready_o        : encoder idle, a sample is accepted when valid_i is high
//   tick_i         : timestep strobe, one timestep per high cycle while running
//   clear_i        : synchronous abort of the running window (no done_o)
//   axon_o         : registered one-cycle spike pulse
//   done_o         : one-cycle pulse on the edge that completes the window
//   spike_count_o  : spikes emitted in the current or most recent window
// -----------------------------------------------------------------------------
module spike_encoder
  import snn_pkg::*;
#(
  parameter int DATA_W = ENC_DATA_W,
  parameter int WINDOW = ENC_WINDOW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          value_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       tick_i,
  input  logic                       clear_i,
  output logic                       axon_o,
  output logic                       done_o,
  output logic [$clog2(WINDOW+1)-1:0] spike_count_o
);

  localparam int STEP_W = $clog2(WINDOW);
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);

  enc_state_t        state, state_nxt;
  logic [DATA_W-1:0] sample;
  logic [STEP_W-1:0] step;
  logic              accept;
  logic              advance;
  logic              last_step;
  logic              carry;

  assign ready_o   = (state == ENC_IDLE);
  assign accept    = ready_o && valid_i;
  // clear_i outranks tick_i, so an aborted timestep never advances the phase.
  assign advance   = (state == ENC_RUN) && tick_i && !clear_i;
  assign last_step = (step == LAST_STEP);

  spike_phase_acc #(
    .DATA_W (DATA_W)
  ) u_phase_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (accept),
    .adv_i    (advance),
    .sample_i (sample),
    .carry_o  (carry)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ENC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt is given a default before the case so every path assigns
  // it; leaving any path unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ENC_IDLE: if (accept)                    state_nxt = ENC_RUN;
      ENC_RUN:  if (clear_i)                   state_nxt = ENC_IDLE;
                else if (tick_i && last_step)  state_nxt = ENC_IDLE;
      default:                                 state_nxt = ENC_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample, step and spike counters, registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample        <= '0;
      step          <= '0;
      spike_count_o <= '0;
      axon_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      // Pulses default low so they last exactly one cycle.
      axon_o <= 1'b0;
      done_o <= 1'b0;
      if (accept) begin
        sample        <= value_i;
        step          <= '0;
        spike_count_o <= '0;
      end else if (advance) begin
        axon_o        <= carry;
        spike_count_o <= spike_count_o + CNT_W'(carry);
        step          <= last_step ? '0 : step + STEP_W'(1);
        done_o        <= last_step;
      end
      // clear_i in RUN only changes state; the partial count stays visible.
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_encoder
// Directed bench for spike_encoder with a rate-coding reference model. The
// model tracks how many ticks of the current window have been taken and
// derives the expected spike count as floor(sample*k / 2^DATA_W), so a spike
// is expected on tick k exactly when that floor increases.
// -----------------------------------------------------------------------------
module tb_spike_encoder;

  localparam int DATA_W = 8;
  localparam int WINDOW = 16;
  localparam int FULL   = 1 << DATA_W;

  logic              clk_i   = 1'b0;
  logic              rst_i   = 1'b0;
  logic [DATA_W-1:0] value_i = '0;
  logic              valid_i = 1'b0;
  logic              tick_i  = 1'b0;
  logic              clear_i = 1'b0;
  logic              ready_o;
  logic              axon_o;
  logic              done_o;
  logic [4:0]        spike_count_o;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  spike_encoder #(
    .DATA_W (DATA_W),
    .WINDOW (WINDOW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .value_i       (value_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .tick_i        (tick_i),
    .clear_i       (clear_i),
    .axon_o        (axon_o),
    .done_o        (done_o),
    .spike_count_o (spike_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit m_busy  = 1'b0;
  bit m_axon  = 1'b0;
  bit m_done  = 1'b0;
  int m_samp  = 0;
  int m_k     = 0;
  int m_count = 0;
  int n_now, n_prev;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy = 1'b0; m_axon = 1'b0; m_done = 1'b0;
      m_samp = 0;    m_k = 0;       m_count = 0;
    end else begin
      m_axon = 1'b0;
      m_done = 1'b0;
      if (!m_busy) begin
        if (valid_i) begin
          m_busy = 1'b1; m_samp = value_i; m_k = 0; m_count = 0;
        end
      end else if (clear_i) begin
        m_busy = 1'b0;
      end else if (tick_i) begin
        m_k++;
        n_now   = (m_samp * m_k) / FULL;
        n_prev  = (m_samp * (m_k - 1)) / FULL;
        m_axon  = (n_now != n_prev);
        m_count = n_now;
        if (m_k == WINDOW) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  // Outputs are registered, so mid-cycle they must equal the model's view.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("ready_o", ready_o, !m_busy);
      check("axon_o", axon_o, m_axon);
      check("done_o", done_o, m_done);
      check("spike_count_o", spike_count_o, m_count);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  // Present one sample, then tick once every `period` cycles until done_o.
  task automatic run_window(input logic [DATA_W-1:0] v, input int period,
                            output logic [15:0] mask, output int ticks,
                            output int cycles, output logic axon_at_done);
    bit t, seen;
    value_i = v; valid_i = 1'b1; tick_i = (period == 1);
    cyc();
    valid_i = 1'b0; value_i = ~v;
    mask = '0; ticks = 0; cycles = 0; seen = 1'b0; axon_at_done = 1'b0;
    while (!seen && cycles < 400) begin
      t = ((cycles % period) == period - 1);
      tick_i = t;
      cyc();
      cycles++;
      if (t) begin
        ticks++;
        if (axon_o && ticks <= 16) mask[ticks-1] = 1'b1;
      end
      if (done_o) begin
        seen = 1'b1;
        axon_at_done = axon_o;
      end
    end
    tick_i = 1'b0;
    check("done_within_budget", seen, 1);
  endtask

  // Tick every cycle of an already running window until done_o.
  task automatic wait_done(output int ticks);
    bit seen;
    seen = 1'b0; ticks = 0;
    tick_i = 1'b1;
    while (!seen && ticks < 100) begin
      cyc();
      ticks++;
      if (done_o) seen = 1'b1;
    end
    tick_i = 1'b0;
    check("wait_done_within_budget", seen, 1);
  endtask

  logic [15:0] mask;
  int          ticks, cycles;
  logic        axon_at_done;

  initial begin
    #1 rst_i = 1'b1;
    #1;
    check("reset_ready", ready_o, 1);
    check("reset_axon", axon_o, 0);
    check("reset_done", done_o, 0);
    check("reset_count", spike_count_o, 0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    cyc();

    // Half intensity, tick every cycle: spikes on even ticks, last on tick 16.
    run_window(8'd128, 1, mask, ticks, cycles, axon_at_done);
    check("v128_mask", mask, 16'hAAAA);
    check("v128_ticks", ticks, 16);
    check("v128_cycles", cycles, 16);
    check("v128_spike_with_done", axon_at_done, 1);
    check("v128_count", spike_count_o, 8);
    check("v128_ready_after", ready_o, 1);
    cyc();

    // Zero intensity: silent window that still completes.
    run_window(8'd0, 1, mask, ticks, cycles, axon_at_done);
    check("v0_mask", mask, 16'h0000);
    check("v0_cycles", cycles, 16);
    check("v0_count", spike_count_o, 0);

    // Full scale: first tick silent, every later tick spikes.
    run_window(8'd255, 1, mask, ticks, cycles, axon_at_done);
    check("v255_mask", mask, 16'hFFFE);
    check("v255_count", spike_count_o, 15);

    // Sparse ticks: one tick every 3 cycles.
    run_window(8'd64, 3, mask, ticks, cycles, axon_at_done);
    check("v64_mask", mask, 16'h8888);
    check("v64_ticks", ticks, 16);
    check("v64_cycles", cycles, 48);
    check("v64_count", spike_count_o, 4);

    // valid_i held with changing values during RUN: only the first is used.
    value_i = 8'd64; valid_i = 1'b1; tick_i = 1'b1;
    cyc();
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        value_i = i[0] ? 8'd255 : 8'd0;
        cyc();
        if (done_o) seen = 1'b1;
      end
      check("held_valid_done_seen", seen, 1);
    end
    check("held_valid_count", spike_count_o, 4);
    value_i = 8'd200; tick_i = 1'b0;
    cyc();
    check("held_valid_accepted_next", ready_o, 0);
    valid_i = 1'b0;
    wait_done(ticks);
    check("v200_ticks", ticks, 16);
    check("v200_count", spike_count_o, 12);
    cyc();

    // clear_i on the 5th tick: abort, partial count of 2 stays visible.
    value_i = 8'd128; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0; tick_i = 1'b1;
    repeat (4) cyc();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0; tick_i = 1'b0;
    check("clear_ready", ready_o, 1);
    check("clear_no_done", done_o, 0);
    check("clear_count_held", spike_count_o, 2);
    tick_i = 1'b1;
    repeat (3) cyc();
    check("clear_idle_ticks_ignored", spike_count_o, 2);
    // clear_i together with valid_i in IDLE still accepts the sample.
    tick_i = 1'b0; clear_i = 1'b1; valid_i = 1'b1; value_i = 8'd16;
    cyc();
    clear_i = 1'b0; valid_i = 1'b0;
    check("idle_clear_accepts", ready_o, 0);
    check("restart_count", spike_count_o, 0);
    wait_done(ticks);
    check("v16_count", spike_count_o, 1);
    cyc();

    // Asynchronous reset between edges in the middle of a window.
    value_i = 8'd255; valid_i = 1'b1;
    cyc();
    valid_i = 1'b0; tick_i = 1'b1;
    repeat (3) cyc();
    check("pre_reset_axon", axon_o, 1);
    check("pre_reset_count", spike_count_o, 2);
    rst_i = 1'b1;
    #1;
    check("async_rst_axon", axon_o, 0);
    check("async_rst_done", done_o, 0);
    check("async_rst_count", spike_count_o, 0);
    check("async_rst_ready", ready_o, 1);
    #1 rst_i = 1'b0; tick_i = 1'b0;
    cyc();
    run_window(8'd128, 1, mask, ticks, cycles, axon_at_done);
    check("post_rst_mask", mask, 16'hAAAA);
    check("post_rst_count", spike_count_o, 8);
    cyc();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
